// File: rtl/hazard_scoreboard.sv
// ID-stage RAW hazard scoreboard that tracks in-flight destinations itself; stall is combinational (zero latency).
// mem_busy freezes the tracker and counter; stalls, flushes and non-writers advance a bubble into EXE.
module hazard_scoreboard #(
  parameter int REG_W      = 4,
  parameter int PIPE_DEPTH = 2,
  parameter int FWD_EN     = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             is_imm,
  input  logic             is_str,
  input  logic             id_wb_en,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_is_load,
  input  logic             mem_busy,
  input  logic             flush,
  output logic             hazard_detected,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dest;
    logic             ld;
  } trk_entry_t;

  // trk[0] is EXE, trk[PIPE_DEPTH-1] is the oldest unwritten result
  trk_entry_t [PIPE_DEPTH-1:0] trk;
  trk_entry_t                  new_entry;
  logic       [PIPE_DEPTH-1:0] match;
  logic                        src2_used;
  logic                        raw;
  logic                        issue;

  assign src2_used = ~is_imm | is_str;

  always_comb begin
    match = '0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      match[k] = trk[k].v & ((src1 == trk[k].dest) | (src2_used & (src2 == trk[k].dest)));
    end
  end

  // With forwarding only a load sitting in EXE cannot be bypassed in time
  generate
    if (FWD_EN != 0) begin : g_fwd
      assign raw = match[0] & trk[0].ld;
    end else begin : g_nofwd
      assign raw = |match;
    end
  endgenerate

  assign hazard_detected = id_valid & ~flush & raw;
  assign issue           = id_valid & id_wb_en & ~hazard_detected & ~flush;

  always_comb begin
    new_entry = '0;
    if (issue) begin
      new_entry.v    = 1'b1;
      new_entry.dest = id_dest;
      new_entry.ld   = id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trk <= '0;
    end else if (!mem_busy) begin
      for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
        trk[k] <= trk[k-1];
      end
      trk[0] <= new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (!mem_busy && hazard_detected && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Four hazard_scoreboard configurations share one randomized input stream; a queue-based reference model predicts each.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [3:0] src1 = '0;
  logic [3:0] src2 = '0;
  logic       is_imm = 1'b0;
  logic       is_str = 1'b0;
  logic       id_wb_en = 1'b0;
  logic [3:0] id_dest = '0;
  logic       id_is_load = 1'b0;
  logic       mem_busy = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] hz;
  logic [15:0] c0, c1, c3;
  logic [1:0]  c2;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_W(4), .PIPE_DEPTH(2), .FWD_EN(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .src1(src1), .src2(src2),
    .is_imm(is_imm), .is_str(is_str), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_is_load(id_is_load), .mem_busy(mem_busy), .flush(flush),
    .hazard_detected(hz[0]), .stall_count(c0));
  hazard_scoreboard #(.REG_W(4), .PIPE_DEPTH(2), .FWD_EN(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .src1(src1), .src2(src2),
    .is_imm(is_imm), .is_str(is_str), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_is_load(id_is_load), .mem_busy(mem_busy), .flush(flush),
    .hazard_detected(hz[1]), .stall_count(c1));
  hazard_scoreboard #(.REG_W(4), .PIPE_DEPTH(2), .FWD_EN(0), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .src1(src1), .src2(src2),
    .is_imm(is_imm), .is_str(is_str), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_is_load(id_is_load), .mem_busy(mem_busy), .flush(flush),
    .hazard_detected(hz[2]), .stall_count(c2));
  hazard_scoreboard #(.REG_W(4), .PIPE_DEPTH(3), .FWD_EN(0), .CNT_W(16)) u3 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .src1(src1), .src2(src2),
    .is_imm(is_imm), .is_str(is_str), .id_wb_en(id_wb_en), .id_dest(id_dest),
    .id_is_load(id_is_load), .mem_busy(mem_busy), .flush(flush),
    .hazard_detected(hz[3]), .stall_count(c3));

  // Reference model: each configuration is a queue of in-flight writers, youngest at the front
  typedef struct {
    bit         v;
    logic [3:0] dest;
    bit         ld;
  } slot_t;

  typedef struct packed {
    logic [3:0]       hz;
    logic [3:0][15:0] cnt;
  } exp_t;

  slot_t pipe [4][$];
  int    cnt_m   [4];
  int    depth_c [4] = '{2, 2, 2, 3};
  bit    fwd_c   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int    cmax_c  [4] = '{65535, 65535, 3, 65535};
  exp_t  exp_q   [$];
  int    checks = 0;
  int    failures = 0;

  function automatic bit model_hz(int i);
    bit s2u;
    s2u = !is_imm || is_str;
    if (!id_valid || flush) return 1'b0;
    for (int j = 0; j < pipe[i].size(); j++) begin
      if (!pipe[i][j].v) continue;
      if (fwd_c[i] && (j != 0 || !pipe[i][j].ld)) continue;
      if (pipe[i][j].dest == src1 || (s2u && pipe[i][j].dest == src2)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    slot_t b;
    b = '{1'b0, 4'd0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      pipe[i].delete();
      for (int j = 0; j < depth_c[i]; j++) pipe[i].push_back(b);
      cnt_m[i] = 0;
    end
  endtask

  task automatic model_step();
    slot_t s, dropped;
    bit    h;
    for (int i = 0; i < 4; i++) begin
      h = model_hz(i);
      if (!mem_busy) begin
        s = '{1'b0, 4'd0, 1'b0};
        if (id_valid && id_wb_en && !h && !flush) s = '{1'b1, id_dest, id_is_load};
        pipe[i].push_front(s);
        dropped = pipe[i].pop_back();
        if (h && cnt_m[i] < cmax_c[i]) cnt_m[i]++;
      end
    end
  endtask

  // One call = one clock cycle; the DUT latched the previous inputs at this edge
  task automatic drive(bit r, bit v, int s1, int s2, bit imm, bit st, bit wb, int d,
                       bit ld, bit busy, bit fl);
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n) model_step();
    rst_n = r;
    if (!r) model_reset();
    id_valid = v; src1 = 4'(s1); src2 = 4'(s2); is_imm = imm; is_str = st;
    id_wb_en = wb; id_dest = 4'(d); id_is_load = ld; mem_busy = busy; flush = fl;
    for (int i = 0; i < 4; i++) begin
      e.hz[i]  = model_hz(i);
      e.cnt[i] = 16'(cnt_m[i]);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(int d, bit ld);
    drive(1'b1, 1'b1, 15, 15, 1'b1, 1'b0, 1'b1, d, ld, 1'b0, 1'b0);
  endtask

  task automatic rd(int s1, int s2, bit imm, bit st, int n);
    repeat (n) drive(1'b1, 1'b1, s1, s2, imm, st, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic int rreg();
    return ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
  endfunction

  exp_t        mon_e;
  logic [15:0] mon_got [4];

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_got[0] = c0;
      mon_got[1] = c1;
      mon_got[2] = {14'd0, c2};
      mon_got[3] = c3;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (hz[i] !== mon_e.hz[i]) begin
          failures++;
          $display("FAIL hazard u%0d t=%0t got=%b want=%b", i, $time, hz[i], mon_e.hz[i]);
        end
        checks++;
        if (mon_got[i] !== mon_e.cnt[i]) begin
          failures++;
          $display("FAIL stall_count u%0d t=%0t got=%0d want=%0d", i, $time, mon_got[i], mon_e.cnt[i]);
        end
      end
    end
  end

  initial begin
    model_reset();
    // held in reset
    repeat (2) drive(1'b0, 1'b1, 3, 3, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0);
    idle(1);
    // RAW on src1: 2 stalls at depth 2, 3 stalls at depth 3, none with forwarding of an ALU result
    wr(3, 1'b0); rd(3, 0, 1'b1, 1'b0, 3); idle(3);
    // src2 ignored for immediates unless the instruction is a store
    wr(5, 1'b0); rd(0, 5, 1'b1, 1'b0, 1); rd(0, 5, 1'b1, 1'b1, 1); idle(3);
    // load-use versus ALU result
    wr(4, 1'b1); rd(1, 4, 1'b0, 1'b0, 2); idle(3);
    wr(4, 1'b0); rd(1, 4, 1'b0, 1'b0, 2); idle(3);
    // flush suppresses the stall and kills the writer in ID
    wr(6, 1'b0);
    drive(1'b1, 1'b1, 6, 0, 1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b0, 1'b1);
    rd(9, 9, 1'b1, 1'b0, 1); idle(3);
    // freeze during a stall
    wr(8, 1'b0);
    repeat (3) drive(1'b1, 1'b1, 8, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    rd(8, 0, 1'b1, 1'b0, 3); idle(3);
    // push the 2-bit counter past saturation, then reset in the middle of a stall
    repeat (3) begin wr(2, 1'b0); rd(2, 0, 1'b1, 1'b0, 3); end
    wr(2, 1'b0); rd(2, 0, 1'b1, 1'b0, 1);
    drive(1'b0, 1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // register 15 and register 0 at the index extremes
    wr(15, 1'b1); rd(15, 0, 1'b0, 1'b0, 2); idle(3);
    // randomized traffic
    repeat (3000) begin
      drive($urandom_range(0, 299) != 0, $urandom_range(0, 99) < 85, rreg(), rreg(),
            $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 70, rreg(), $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
    end
    idle(2);
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
